// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised line, one-hot FSM, mid-bit sampling.
// data holds the last good byte; rx_done / frame_err are single-cycle pulses.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic [3:0] fsm_state
);

  // Clocks per bit; configurations with C < 4 are not supported.
  localparam int C  = CLK_FREQ / BAUD_RATE;
  localparam int H  = C / 2;
  localparam int CW = $clog2(C);
  localparam logic [CW-1:0] C_LAST = CW'(C - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    RX    = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
  logic [1:0]      sync_fill;

  assign fsm_state = state;

  // Outputs carry no handshake: rx_done marks one cycle in which data is new,
  // frame_err marks one cycle in which a frame was discarded; never both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      sync_fill <= 2'd0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      // Edge detection is held off until the synchroniser holds only
      // post-reset samples, so a line still low at release is not a start.
      if (sync_fill != 2'd3) sync_fill <= sync_fill + 2'd1;

      case (state)
        IDLE: begin
          if (sync_fill == 2'd3 && rx_prev && !rx_sync) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == H_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? IDLE : RX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX: begin
          if (cnt == C_LAST) begin
            shift   <= {rx_sync, shift[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == C_LAST) begin
            if (rx_sync) begin
              data    <= shift;
              rx_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at C=4, H=2: framing, glitch, back-to-back, reset.
module tb_uart_rx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic [3:0] fsm_state;

  int errors = 0;
  int checks = 0;

  int edge_n = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_done_edge = -1;
  int last_err_edge = -1;
  int first_done_edge = -1;
  int e0;
  logic saw_start = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_FREQ (100_000_000),
    .BAUD_RATE(25_000_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // One clock step; outputs are observed 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (rx_done) begin
      done_cnt++;
      if (first_done_edge < 0) first_done_edge = edge_n;
      last_done_edge = edge_n;
      got_q.push_back(data);
    end
    if (frame_err) begin
      err_cnt++;
      last_err_edge = edge_n;
    end
    if (rx_done && frame_err) both_cnt++;
    if (fsm_state == 4'b0010) saw_start = 1'b1;
  endtask

  task automatic clear_monitor();
    done_cnt = 0;
    err_cnt = 0;
    last_done_edge = -1;
    last_err_edge = -1;
    first_done_edge = -1;
    saw_start = 1'b0;
    got_q.delete();
  endtask

  // Driver tasks
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: received bytes against the expected queue
  task automatic check_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check({tag, "_byte"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_state", fsm_state, 4'b0001);
    check("reset_data", data, 8'h00);
    check("reset_done", rx_done, 1'b0);
    check("reset_ferr", frame_err, 1'b0);
    repeat (6) tick();

    // Good frame 0x48
    clear_monitor();
    exp_q.push_back(8'h48);
    e0 = edge_n + 1;
    send_frame(8'h48, 1'b1);
    repeat (4) tick();
    check("h48_done_edge", last_done_edge, e0 + 40);
    check("h48_data", data, 8'h48);
    check("h48_ferr", err_cnt, 0);
    check("h48_state", fsm_state, 4'b0001);
    check_bytes("h48");

    // 0xA5 with stop bit low
    clear_monitor();
    e0 = edge_n + 1;
    send_frame(8'hA5, 1'b0);
    repeat (6) tick();
    check("a5_ferr_cnt", err_cnt, 1);
    check("a5_ferr_edge", last_err_edge, e0 + 40);
    check("a5_done_cnt", done_cnt, 0);
    check("a5_data_held", data, 8'h48);
    check("a5_state", fsm_state, 4'b0001);

    // One-clock glitch
    clear_monitor();
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (12) tick();
    check("glitch_saw_start", saw_start, 1'b1);
    check("glitch_state", fsm_state, 4'b0001);
    check("glitch_done", done_cnt, 0);
    check("glitch_ferr", err_cnt, 0);

    // Back-to-back 0x55, 0xFF
    clear_monitor();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hFF);
    e0 = edge_n + 1;
    send_frame(8'h55, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) tick();
    check("b2b_first_edge", first_done_edge, e0 + 40);
    check("b2b_spacing", last_done_edge - first_done_edge, 40);
    check("b2b_ferr", err_cnt, 0);
    check("b2b_data", data, 8'hFF);
    check_bytes("b2b");

    // Reset during bit 3 of 0x3C (LSB first: 0,0,1,1,...)
    clear_monitor();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx = 1'b1;
    repeat (50) tick();
    check("rst_mid_state", fsm_state, 4'b0001);
    check("rst_mid_done", done_cnt, 0);
    check("rst_mid_ferr", err_cnt, 0);
    check("rst_mid_data", data, 8'h00);

    clear_monitor();
    exp_q.push_back(8'h3C);
    e0 = edge_n + 1;
    send_frame(8'h3C, 1'b1);
    repeat (4) tick();
    check("h3c_done_edge", last_done_edge, e0 + 40);
    check("h3c_data", data, 8'h3C);
    check("h3c_ferr", err_cnt, 0);
    check_bytes("h3c");

    check("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 Derived constant C = CLK_FREQ/BAUD_RATE (integer division) and H = C/2; configurations with C < 4 SHALL be unsupported.
REQ-004 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-007 data  output  8  last correctly framed byte; held until the next good frame.
REQ-008 rx_done  output  1  one-cycle pulse marking a new valid byte on data.
REQ-009 frame_err  output  1  one-cycle pulse when the stop bit samples low.

Function
REQ-010 rx SHALL pass through a two-flop synchroniser (rx_meta, then rx_sync); a third register rx_prev SHALL hold the previous rx_sync.
REQ-011 FSM SHALL be one-hot, 4 bits: IDLE=0001, START=0010, RX=0100, STOP=1000; the state register SHALL be named state.
REQ-012 IDLE: on rx_prev=1 and rx_sync=0 (falling edge) -> START, cnt<=0; a line held low SHALL NOT retrigger.
REQ-013 START: cnt increments each clock; at cnt=H-1, rx_sync=0 -> RX with cnt<=0, bit index<=0; rx_sync=1 -> IDLE (glitch rejected, no output pulse).
REQ-014 RX: cnt increments each clock; at cnt=C-1, rx_sync SHALL be shifted into the shift register MSB with a right shift (LSB-first assembly), cnt<=0, bit index +1; after the 8th sample -> STOP.
REQ-015 STOP: at cnt=C-1, sample rx_sync; 1 -> data<=shift register, rx_done pulses; 0 -> frame_err pulses, data unchanged; either way -> IDLE.
REQ-016 Timing: with E0 = first clock edge at which rx_meta captures 0, the stop-bit sample SHALL occur at edge E(2+H+9C); rx_done or frame_err SHALL be high for exactly the one cycle after that edge.
REQ-017 Data bit k (k=0..7) SHALL be sampled at edge E(2+H+(k+1)C).
REQ-018 rx_done and frame_err SHALL never be high in the same cycle, and each SHALL stay high for at most one cycle per frame.
REQ-019 A new falling edge arriving in the cycle the FSM returns to IDLE SHALL be detected on the following clock; back-to-back frames with one stop bit SHALL be received without loss.
REQ-020 cnt SHALL be wide enough to hold C-1 and SHALL never wrap within a state.
REQ-021 rx changes during START, RX or STOP other than at sample points SHALL have no effect.

Reset
REQ-022 While rst=1 at a clock edge: state<=IDLE, cnt<=0, bit index<=0, shift register<=0, data<=8'h00, rx_done<=0, frame_err<=0, and rx_meta, rx_sync, rx_prev<=1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no rx_done or frame_err pulse; the remainder of that frame SHALL NOT be decoded as a new start, except when a genuine falling edge occurs after reset release.

Verification (CLK_FREQ=100_000_000, BAUD_RATE=25_000_000 -> C=4, H=2; 10 ns clock)
REQ-024 Reset for 1 cycle with rx=1 -> state=0001, data=8'h00, rx_done=0, frame_err=0.
REQ-025 Drive the frame for 8'h48 (0,0,0,0,1,0,0,1,0,1) -> single rx_done pulse at E(40), data=8'h48, frame_err=0, state back to 0001.
REQ-026 Drive 8'hA5 with the stop bit forced 0 -> frame_err single pulse at E(40), rx_done=0, data retains its previous value.
REQ-027 Drive rx low for 1 clock only, then high -> state visits 0010 and returns to 0001; no rx_done, no frame_err.
REQ-028 Send 8'h55 then 8'hFF back-to-back -> two rx_done pulses spaced 10*C=40 clocks apart, with data=8'h55 then 8'hFF.
REQ-029 Assert rst during bit 3 of a frame for 1 cycle, then rx=1 idle -> state=0001 and no output pulse; a following frame with 8'h3C is received correctly.
